// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: sync, tick-sampled filter,
// edge pulses, long-press and auto-repeat pulses per channel.
//
// Ports:
//   clk      system clock (single domain)
//   rst      synchronous active-high reset, clears all state
//   i_btn    raw asynchronous button levels, active-high
//   o_level  debounced level per channel
//   o_rise   1-clk pulse on o_level 0->1
//   o_fall   1-clk pulse on o_level 1->0
//   o_long   1-clk pulse once per press after HOLD_TICKS ticks held
//   o_rep    1-clk pulse every REPEAT_TICKS ticks after o_long
module btn_debounce_multi #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 100_000,
    parameter int DEPTH        = 8,
    parameter int HOLD_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_rep
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
    localparam bit REP_EN = (REPEAT_TICKS > 0);

    localparam logic [CW-1:0] C_TOP  = CW'(TICK_DIV - 1);
    localparam logic [HW:0]   C_HOLD = (HW + 1)'(HOLD_TICKS);
    localparam logic [HW:0]   C_WRAP = (HW + 1)'(HOLD_TICKS + REPEAT_TICKS);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [CW-1:0]   r_pre;
    logic            w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_pre == C_TOP);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + CW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DEPTH-1:0] r_sr;
        logic             r_level;
        logic             r_rise;
        logic             r_fall;
        logic             r_long;
        logic             r_rep;
        logic [HW-1:0]    r_hold;

        logic [DEPTH-1:0] w_sr_nx;
        logic             w_lvl_nx;
        logic [HW:0]      w_hold_inc;

        assign w_sr_nx    = {r_sr[DEPTH-2:0], r_sync2[g]};
        assign w_hold_inc = {1'b0, r_hold} + (HW + 1)'(1);

        always_comb begin
            w_lvl_nx = r_level;
            if (&w_sr_nx) begin
                w_lvl_nx = 1'b1;
            end else if (~|w_sr_nx) begin
                w_lvl_nx = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_long <= 1'b0;
            r_rep  <= 1'b0;
            if (rst) begin
                r_sr    <= '0;
                r_level <= 1'b0;
                r_hold  <= '0;
            end else begin
                if (w_tick) begin
                    r_sr    <= w_sr_nx;
                    r_level <= w_lvl_nx;
                    r_rise  <= w_lvl_nx & ~r_level;
                    r_fall  <= ~w_lvl_nx & r_level;
                end
                // A release on this tick wins over any long/repeat pulse.
                if (!r_level || (w_tick && !w_lvl_nx)) begin
                    r_hold <= '0;
                end else if (w_tick) begin
                    if (w_hold_inc == C_HOLD) begin
                        r_hold <= C_HOLD[HW-1:0];
                        r_long <= 1'b1;
                    end else if (!REP_EN && ({1'b0, r_hold} == C_HOLD)) begin
                        r_hold <= r_hold;
                    end else if (REP_EN && (w_hold_inc == C_WRAP)) begin
                        // Reload so the next repeat is REPEAT_TICKS away.
                        r_hold <= C_HOLD[HW-1:0];
                        r_rep  <= 1'b1;
                    end else begin
                        r_hold <= w_hold_inc[HW-1:0];
                    end
                end
            end
        end

        assign o_level[g] = r_level;
        assign o_rise[g]  = r_rise;
        assign o_fall[g]  = r_fall;
        assign o_long[g]  = r_long;
        assign o_rep[g]   = r_rep;
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: reset, bounce reject,
// press latency, long press / repeat, channel independence, mid-hold reset.
module tb_btn_debounce_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] i_btn = 2'b00;
    logic [1:0] o_level;
    logic [1:0] o_rise;
    logic [1:0] o_fall;
    logic [1:0] o_long;
    logic [1:0] o_rep;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_CH(2),
        .TICK_DIV(4),
        .DEPTH(4),
        .HOLD_TICKS(8),
        .REPEAT_TICKS(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .i_btn(i_btn),
        .o_level(o_level),
        .o_rise(o_rise),
        .o_fall(o_fall),
        .o_long(o_long),
        .o_rep(o_rep)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_rise[2], n_fall[2], n_long[2], n_rep[2];
    int t_rise[2], t_fall[2], t_long[2], t_rep0[2], t_rep1[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        for (int c = 0; c < 2; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0; n_rep[c] = 0;
            t_rise[c] = -1; t_fall[c] = -1; t_long[c] = -1;
            t_rep0[c] = -1; t_rep1[c] = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (o_rise[c] === 1'b1) begin n_rise[c]++; t_rise[c] = cyc; end
            if (o_fall[c] === 1'b1) begin n_fall[c]++; t_fall[c] = cyc; end
            if (o_long[c] === 1'b1) begin n_long[c]++; t_long[c] = cyc; end
            if (o_rep[c] === 1'b1) begin
                if (n_rep[c] == 0) t_rep0[c] = cyc;
                n_rep[c]++;
                t_rep1[c] = cyc;
            end
        end
    endtask

    task automatic wait_lvl(input int c, input logic v, input int lim,
                            output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            step();
            if (o_level[c] === v) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("wait_lvl", 32'(o_level[c]), 32'(v));
    endtask

    int at, k, rs;
    int pat_v[5] = '{1, 0, 1, 0, 0};
    int pat_n[5] = '{7, 2, 2, 2, 40};

    initial begin
        clr_mon();

        // reset with both buttons already pressed
        rst = 1'b1;
        i_btn = 2'b11;
        repeat (3) begin
            step();
            check("rst_out", 32'({o_level, o_rise, o_fall, o_long, o_rep}), 0);
        end
        rst = 1'b0;
        k = cyc;
        wait_lvl(0, 1'b1, 40, at);
        check("rst_lat_ok", 32'(int'((at - k) inside {[15:18]})), 1);
        check("rst_lvl", 32'(o_level), 32'(2'b11));
        check("rst_rise1_t", 32'(t_rise[1]), 32'(at));
        i_btn = 2'b00;
        wait_lvl(0, 1'b0, 40, at);
        repeat (5) step();

        // bounce train on ch0, every stretch too short
        clr_mon();
        for (int p = 0; p < 5; p++) begin
            i_btn[0] = pat_v[p][0];
            repeat (pat_n[p]) step();
        end
        check("bounce_rise", 32'(n_rise[0]), 0);
        check("bounce_fall", 32'(n_fall[0]), 0);
        check("bounce_lvl", 32'(o_level[0]), 0);

        // clean press on ch0
        clr_mon();
        i_btn[0] = 1'b1;
        k = cyc;
        wait_lvl(0, 1'b1, 30, at);
        rs = at;
        check("press_win", 32'(int'((at - k) inside {[15:18]})), 1);
        check("press_rise_t", 32'(t_rise[0]), 32'(at));
        step();
        check("rise_1clk", 32'(o_rise[0]), 0);
        check("press_nfall", 32'(n_fall[0]), 0);
        check("ch1_quiet", 32'(n_rise[1] + n_fall[1] + n_long[1] + n_rep[1]
                               + int'(o_level[1])), 0);

        // long press and repeat, release on the would-be repeat tick
        while (cyc < rs + 64) step();
        check("long_t", 32'(t_long[0]), 32'(rs + 32));
        check("long_n", 32'(n_long[0]), 1);
        check("rep0_t", 32'(t_rep0[0]), 32'(rs + 48));
        check("rep1_t", 32'(t_rep1[0]), 32'(rs + 64));
        check("rep_n", 32'(n_rep[0]), 2);
        i_btn[0] = 1'b0;
        k = cyc;
        wait_lvl(0, 1'b0, 30, at);
        check("rel_win", 32'(int'((at - k) inside {[15:18]})), 1);
        check("rel_fall_t", 32'(t_fall[0]), 32'(at));
        repeat (30) step();
        check("rel_rep_n", 32'(n_rep[0]), 2);
        check("rel_long_n", 32'(n_long[0]), 1);

        // both channels together, then release ch1 only
        clr_mon();
        i_btn = 2'b11;
        wait_lvl(0, 1'b1, 30, at);
        rs = at;
        check("ind_rise", 32'(o_rise), 32'(2'b11));
        while (cyc < rs + 33) step();
        i_btn[1] = 1'b0;
        while (cyc < rs + 70) step();
        check("ind_fall1_n", 32'(n_fall[1]), 1);
        check("ind_fall1_t", 32'(t_fall[1]), 32'(rs + 48));
        check("ind_fall0_n", 32'(n_fall[0]), 0);
        check("ind_rep0_t0", 32'(t_rep0[0]), 32'(rs + 48));
        check("ind_rep0_t1", 32'(t_rep1[0]), 32'(rs + 64));
        check("ind_rep1_n", 32'(n_rep[1]), 0);
        check("ind_long1_n", 32'(n_long[1]), 1);
        check("ind_lvl", 32'(o_level), 32'(2'b01));

        // reset while ch0 is held
        i_btn = 2'b00;
        wait_lvl(0, 1'b0, 30, at);
        repeat (4) step();
        clr_mon();
        i_btn[0] = 1'b1;
        wait_lvl(0, 1'b1, 30, at);
        rs = at;
        while (cyc < rs + 20) step();
        rst = 1'b1;
        step();
        check("mid_rst_out", 32'({o_level, o_rise, o_fall, o_long, o_rep}), 0);
        rst = 1'b0;
        k = cyc;
        wait_lvl(0, 1'b1, 30, at);
        check("mid_win", 32'(int'((at - k) inside {[15:18]})), 1);
        check("mid_nfall", 32'(n_fall[0]), 0);
        check("mid_nrise", 32'(n_rise[0]), 2);
        rs = at;
        while (cyc < rs + 34) step();
        check("mid_long_t", 32'(t_long[0]), 32'(rs + 32));
        check("mid_long_n", 32'(n_long[0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised N-channel push-button conditioner: the successor to the single-button debouncers. Each channel gets a 2-flop synchroniser, a shared sample-tick prescaler, a DEPTH-sample shift-register filter, and one-cycle rise/fall pulses. Each channel also has long-press and auto-repeat pulse generation. It sits between board button pins and the control FSMs (stopwatch, counter, UART command logic).

## Interface
- N_CH, default 4: number of independent button channels (>=1).
- TICK_DIV, default 100_000: clk cycles per sample tick (>=1). The default gives 1 kHz at 100 MHz.
- DEPTH, default 8: consecutive equal samples required to accept a new level (>=2).
- HOLD_TICKS, default 1000: sample ticks of continuous press before the long-press pulse (>=1).
- REPEAT_TICKS, default 200: ticks between auto-repeat pulses after long press; 0 disables repeat.
- clk  input  1  system clock. One clock domain only.
- rst  input  1  reset: synchronous, active-high. All state is cleared on the clk edge where rst=1.
- i_btn  input  N_CH  raw, asynchronous, bouncing button levels. Active-high.
- o_level  output  N_CH  debounced stable level per channel.
- o_rise  output  N_CH  one-clk pulse when o_level goes 0->1.
- o_fall  output  N_CH  one-clk pulse when o_level goes 1->0.
- o_long  output  N_CH  one-clk pulse, once per press, after HOLD_TICKS ticks held.
- o_rep  output  N_CH  one-clk pulse every REPEAT_TICKS ticks after o_long while still held.

## Operation
- Synchroniser: per channel, sync1 <= i_btn, then sync2 <= sync1. Only sync2 is used downstream.
- Prescaler: a single shared counter, width $clog2(TICK_DIV) (min 1).
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - The internal tick is high for the one cycle where count == TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- Filter, per channel, on tick only:
  - sr <= {sr[DEPTH-2:0], sync2}.
  - If the new sr is all ones and o_level=0: o_level<=1 and o_rise<=1.
  - If the new sr is all zeros and o_level=1: o_level<=0 and o_fall<=1.
  - Any mixed pattern leaves o_level unchanged.
- Hold counter, per channel:
  - Width $clog2(HOLD_TICKS+REPEAT_TICKS+1).
  - Cleared whenever o_level=0, including on the edge that sets o_fall.
  - While o_level=1, it increments on each tick.
  - When it reaches HOLD_TICKS, o_long<=1.
  - If REPEAT_TICKS>0, it then reloads to HOLD_TICKS on each tick where count == HOLD_TICKS+REPEAT_TICKS, and o_rep<=1 on that tick. This gives a repeat period of exactly REPEAT_TICKS ticks.
  - If REPEAT_TICKS=0, it saturates at HOLD_TICKS; no further o_long or o_rep.
- Pulse outputs (o_rise, o_fall, o_long, o_rep) are registered. They default to 0 every cycle unless set on that edge, so every pulse is exactly 1 clk wide.
- Channels are fully independent. Simultaneous events on different channels each pulse in the same cycle.
- o_rise and o_fall never assert together on one channel. o_long and o_rise never coincide, since the hold count is still 0 at rise.

## Timing
- Reset values: sync1, sync2, sr, prescaler count and hold count are all 0. All outputs (o_level, o_rise, o_fall, o_long, o_rep) are 0.
- Reset mid-press:
  - Outputs drop to 0 on the reset edge, with no o_fall pulse.
  - After release, a still-pressed button must re-qualify through DEPTH fresh ticks.
  - This produces a new o_rise.
- Acceptance latency, measured from an i_btn edge at clk edge k to the o_level/o_rise edge:
  - Range is k+(DEPTH-1)*TICK_DIV+3 to k+DEPTH*TICK_DIV+2 inclusive.
  - This holds provided i_btn stays stable and meets setup at edge k.
  - Release latency is identical.
- Rejection:
  - A pulse shorter than (DEPTH-1)*TICK_DIV+1 clk never changes o_level.
  - The same applies to any bounce train whose stable stretches are shorter than that.
- Long press: o_long asserts exactly HOLD_TICKS*TICK_DIV clk after o_rise (tick-aligned).
- Repeat: the first o_rep comes REPEAT_TICKS*TICK_DIV clk after o_long; subsequent ones follow at the same period.
- Release during hold: no o_long or o_rep after the o_fall edge. A release on the same tick that would have issued o_long/o_rep suppresses that pulse, because o_level=0 wins.

## Test plan
Bench parameters: N_CH=2, TICK_DIV=4, DEPTH=4, HOLD_TICKS=8, REPEAT_TICKS=4.
- Reset: hold rst=1 for 3 clk with i_btn=2'b11, then rst=0. All outputs are 0 during reset. o_level becomes 2'b11 no earlier than 15 clk after rst release.
- Bounce reject: ch0 pattern high 7, low 2, high 2, low 2, then low. o_level[0] stays 0 and no pulses occur on ch0.
- Clean press: ch0 goes high at edge k and stays high.
  - o_level[0] rises and o_rise[0] pulses for 1 clk, at an edge within [k+15, k+18].
  - o_fall stays 0.
  - ch1 outputs all stay 0.
- Long press and repeat: keep ch0 high after the rise.
  - o_long[0] pulses at rise+32 clk.
  - o_rep[0] pulses at rise+48 and rise+64 clk.
  - Release then gives o_fall[0] within 15-18 clk and no further o_rep.
- Independent channels: press ch0 and ch1 on the same edge. o_rise=2'b11 in the same cycle. Release ch1 only: only o_fall[1] pulses, and ch0 repeats continue undisturbed.
- Reset mid-hold: assert rst for 1 clk at rise+20 while ch0 is held.
  - Outputs go to 0 with no o_fall.
  - o_rise[0] recurs within 15-18 clk after reset release.
  - o_long[0] comes 32 clk after that new rise.
